// File: rtl/dtcm_arb.sv
// rtl/dtcm_arb.sv - two-requester DTCM arbiter with in-order response routing via an ID FIFO.
// Optional macro DTCM_ARB_RR_EN selects round-robin arbitration; otherwise lsu has fixed priority.
module dtcm_arb #(
  parameter int DTCM_ADDR_WIDTH = 16,
  parameter int XLEN            = 32,
  parameter int OUTS_DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lsu_cmd_valid,
  output logic                       lsu_cmd_ready,
  input  logic                       lsu_cmd_read,
  input  logic [DTCM_ADDR_WIDTH-1:0] lsu_cmd_addr,
  input  logic [XLEN-1:0]            lsu_cmd_wdata,
  input  logic [XLEN/8-1:0]          lsu_cmd_wmask,
  output logic                       lsu_rsp_valid,
  input  logic                       lsu_rsp_ready,
  output logic [XLEN-1:0]            lsu_rsp_rdata,
  input  logic                       ext_cmd_valid,
  output logic                       ext_cmd_ready,
  input  logic                       ext_cmd_read,
  input  logic [DTCM_ADDR_WIDTH-1:0] ext_cmd_addr,
  input  logic [XLEN-1:0]            ext_cmd_wdata,
  input  logic [XLEN/8-1:0]          ext_cmd_wmask,
  output logic                       ext_rsp_valid,
  input  logic                       ext_rsp_ready,
  output logic [XLEN-1:0]            ext_rsp_rdata,
  output logic                       dtcm_cmd_valid,
  input  logic                       dtcm_cmd_ready,
  output logic                       dtcm_cmd_read,
  output logic [DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr,
  output logic [XLEN-1:0]            dtcm_cmd_wdata,
  output logic [XLEN/8-1:0]          dtcm_cmd_wmask,
  input  logic                       dtcm_rsp_valid,
  output logic                       dtcm_rsp_ready,
  input  logic [XLEN-1:0]            dtcm_rsp_rdata,
  output logic                       arb_err
);

  localparam int IW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;

  logic [IW-1:0] widx_q, widx_d, ridx_q, ridx_d;
  logic          wwrap_q, wwrap_d, rwrap_q, rwrap_d;
  logic          fifo_q [OUTS_DEPTH];
  logic          lock_q, lock_d, lock_id_q, lock_id_d;
  logic          err_q, err_d;
`ifdef DTCM_ARB_RR_EN
  logic          rr_q, rr_d;
`endif

  logic gnt, gnt_valid, empty, full, cmd_ok, push, pop, head;

  // gnt: 0 = lsu, 1 = ext; a locked grant is never re-arbitrated
  always_comb begin
    gnt = 1'b0;
    if (lock_q) begin
      gnt = lock_id_q;
    end else begin
`ifdef DTCM_ARB_RR_EN
      if (rr_q) gnt = ext_cmd_valid | ~lsu_cmd_valid;
      else      gnt = ~lsu_cmd_valid & ext_cmd_valid;
`else
      gnt = ~lsu_cmd_valid & ext_cmd_valid;
`endif
    end
  end

  assign gnt_valid = gnt ? ext_cmd_valid : lsu_cmd_valid;
  assign empty     = (widx_q == ridx_q) && (wwrap_q == rwrap_q);
  assign full      = (widx_q == ridx_q) && (wwrap_q != rwrap_q);

  assign cmd_ok         = dtcm_cmd_ready & ~full & ~rst;
  assign dtcm_cmd_valid = gnt_valid & ~full & ~rst;
  assign lsu_cmd_ready  = cmd_ok & ~gnt;
  assign ext_cmd_ready  = cmd_ok & gnt;
  assign dtcm_cmd_read  = gnt ? ext_cmd_read  : lsu_cmd_read;
  assign dtcm_cmd_addr  = gnt ? ext_cmd_addr  : lsu_cmd_addr;
  assign dtcm_cmd_wdata = gnt ? ext_cmd_wdata : lsu_cmd_wdata;
  assign dtcm_cmd_wmask = gnt ? ext_cmd_wmask : lsu_cmd_wmask;
  assign push           = dtcm_cmd_valid & dtcm_cmd_ready;

  assign head           = fifo_q[ridx_q];
  assign lsu_rsp_valid  = dtcm_rsp_valid & ~empty & ~head & ~rst;
  assign ext_rsp_valid  = dtcm_rsp_valid & ~empty & head & ~rst;
  assign lsu_rsp_rdata  = dtcm_rsp_rdata;
  assign ext_rsp_rdata  = dtcm_rsp_rdata;
  // With nothing outstanding, any beat is swallowed and flagged
  assign dtcm_rsp_ready = empty | (head ? ext_rsp_ready : lsu_rsp_ready);
  assign pop            = dtcm_rsp_valid & dtcm_rsp_ready & ~empty;
  assign arb_err        = err_q;

  always_comb begin
    widx_d    = widx_q;
    wwrap_d   = wwrap_q;
    ridx_d    = ridx_q;
    rwrap_d   = rwrap_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q | (dtcm_rsp_valid & empty);
    if (push) begin
      if (widx_q == IW'(OUTS_DEPTH - 1)) begin
        widx_d  = '0;
        wwrap_d = ~wwrap_q;
      end else begin
        widx_d = widx_q + 1'b1;
      end
    end
    if (pop) begin
      if (ridx_q == IW'(OUTS_DEPTH - 1)) begin
        ridx_d  = '0;
        rwrap_d = ~rwrap_q;
      end else begin
        ridx_d = ridx_q + 1'b1;
      end
    end
    if (push) begin
      lock_d = 1'b0;
    end else if (dtcm_cmd_valid && !dtcm_cmd_ready) begin
      lock_d    = 1'b1;
      lock_id_d = gnt;
    end else if (!gnt_valid) begin
      lock_d = 1'b0;
    end
  end

`ifdef DTCM_ARB_RR_EN
  assign rr_d = push ? ~gnt : rr_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx_q    <= '0;
      wwrap_q   <= 1'b0;
      ridx_q    <= '0;
      rwrap_q   <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef DTCM_ARB_RR_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      widx_q    <= widx_d;
      wwrap_q   <= wwrap_d;
      ridx_q    <= ridx_d;
      rwrap_q   <= rwrap_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
`ifdef DTCM_ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  // ID storage needs no reset: entries are only read between push and pop
  always_ff @(posedge clk) begin
    if (push) fifo_q[widx_q] <= gnt;
  end

endmodule

// File: tb/tb_dtcm_arb.sv
// tb/tb_dtcm_arb.sv - scoreboard bench for dtcm_arb with a small DTCM response model.
module tb_dtcm_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_cmd_valid = 0, lsu_cmd_read = 0, lsu_rsp_ready = 1;
  logic [15:0] lsu_cmd_addr = 0;
  logic [31:0] lsu_cmd_wdata = 0;
  logic [3:0]  lsu_cmd_wmask = 0;
  logic        ext_cmd_valid = 0, ext_cmd_read = 0, ext_rsp_ready = 1;
  logic [15:0] ext_cmd_addr = 0;
  logic [31:0] ext_cmd_wdata = 0;
  logic [3:0]  ext_cmd_wmask = 0;
  logic        dtcm_cmd_ready = 1, dtcm_rsp_valid = 0;
  logic [31:0] dtcm_rsp_rdata = 0;
  logic        lsu_cmd_ready, lsu_rsp_valid, ext_cmd_ready, ext_rsp_valid;
  logic [31:0] lsu_rsp_rdata, ext_rsp_rdata, dtcm_cmd_wdata;
  logic        dtcm_cmd_valid, dtcm_cmd_read, dtcm_rsp_ready, arb_err;
  logic [15:0] dtcm_cmd_addr;
  logic [3:0]  dtcm_cmd_wmask;

  dtcm_arb #(.DTCM_ADDR_WIDTH(16), .XLEN(32), .OUTS_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
    .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(ext_cmd_ready), .ext_cmd_read(ext_cmd_read),
    .ext_cmd_addr(ext_cmd_addr), .ext_cmd_wdata(ext_cmd_wdata), .ext_cmd_wmask(ext_cmd_wmask),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready), .ext_rsp_rdata(ext_rsp_rdata),
    .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready), .dtcm_cmd_read(dtcm_cmd_read),
    .dtcm_cmd_addr(dtcm_cmd_addr), .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
    .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready), .dtcm_rsp_rdata(dtcm_rsp_rdata),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [15:0] exp_cmd[$];
  logic [32:0] exp_rsp[$];
  logic [31:0] mem_q[$];
  bit          auto_rsp = 0, cmd_hs_s = 0, rsp_hs_s = 0;
  logic [15:0] cmd_addr_s = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {16'hC0DE, a};
  endfunction

  // DTCM model: answers every accepted command in order, one cycle later at the earliest
  always @(negedge clk) begin
    cmd_hs_s   = dtcm_cmd_valid && dtcm_cmd_ready;
    cmd_addr_s = dtcm_cmd_addr;
    rsp_hs_s   = dtcm_rsp_valid && dtcm_rsp_ready;
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      mem_q.delete();
    end else begin
      if (rsp_hs_s && mem_q.size() > 0) void'(mem_q.pop_front());
      if (cmd_hs_s) mem_q.push_back(mem_data(cmd_addr_s));
    end
    if (auto_rsp) begin
      if (mem_q.size() > 0) begin
        dtcm_rsp_valid = 1;
        dtcm_rsp_rdata = mem_q[0];
      end else begin
        dtcm_rsp_valid = 0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (!rst) begin
      if (dtcm_cmd_valid && dtcm_cmd_ready) begin
        if (exp_cmd.size() == 0) chk("cmd_unexpected", {16'h0, dtcm_cmd_addr}, 32'hFFFF_FFFF);
        else chk("cmd_addr", {16'h0, dtcm_cmd_addr}, {16'h0, exp_cmd.pop_front()});
      end
      if (lsu_rsp_valid && ext_rsp_valid) chk("rsp_both_valid", 1, 0);
      if (lsu_rsp_valid && lsu_rsp_ready) begin
        if (exp_rsp.size() == 0) chk("lsu_rsp_unexpected", lsu_rsp_rdata, 32'hFFFF_FFFF);
        else begin
          e = exp_rsp.pop_front();
          chk("lsu_rsp_id", 0, {31'h0, e[32]});
          chk("lsu_rsp_data", lsu_rsp_rdata, e[31:0]);
        end
      end
      if (ext_rsp_valid && ext_rsp_ready) begin
        if (exp_rsp.size() == 0) chk("ext_rsp_unexpected", ext_rsp_rdata, 32'hFFFF_FFFF);
        else begin
          e = exp_rsp.pop_front();
          chk("ext_rsp_id", 1, {31'h0, e[32]});
          chk("ext_rsp_data", ext_rsp_rdata, e[31:0]);
        end
      end
    end
  end

  task automatic issue(input bit id, input logic [15:0] a);
    bit ok;
    ok = 0;
    exp_cmd.push_back(a);
    exp_rsp.push_back({id, mem_data(a)});
    if (!id) begin lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = a; end
    else     begin ext_cmd_valid = 1; ext_cmd_read = 1; ext_cmd_addr = a; end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (id ? ext_cmd_ready : lsu_cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("issue_timeout", 0, 1);
    @(posedge clk); #1;
    if (!id) lsu_cmd_valid = 0; else ext_cmd_valid = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      if (exp_rsp.size() == 0 && exp_cmd.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", exp_rsp.size() + exp_cmd.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] la, ea;
    bit g;
    // reset with activity on every input that could leak through
    lsu_cmd_valid = 1; ext_cmd_valid = 1; dtcm_rsp_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lsu_cmd_ready", lsu_cmd_ready, 0);
    chk("rst_ext_cmd_ready", ext_cmd_ready, 0);
    chk("rst_dtcm_cmd_valid", dtcm_cmd_valid, 0);
    chk("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
    chk("rst_ext_rsp_valid", ext_rsp_valid, 0);
    chk("rst_arb_err", arb_err, 0);
    lsu_cmd_valid = 0; ext_cmd_valid = 0; dtcm_rsp_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    auto_rsp = 1;

    // both requesters always valid
    la = 16'h0100; ea = 16'h0200;
    lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = la;
    ext_cmd_valid = 1; ext_cmd_read = 1; ext_cmd_addr = ea;
    for (int i = 0; i < 4; i++) begin
`ifdef DTCM_ARB_RR_EN
      g = i[0];
`else
      g = 0;
`endif
      exp_cmd.push_back(g ? ea : la);
      exp_rsp.push_back({g, mem_data(g ? ea : la)});
      @(negedge clk);
      chk("arb_lsu_ready", lsu_cmd_ready, {31'h0, !g});
      chk("arb_ext_ready", ext_cmd_ready, {31'h0, g});
      @(posedge clk); #1;
      if (g) ea = ea + 16'h4; else la = la + 16'h4;
      lsu_cmd_addr = la; ext_cmd_addr = ea;
    end
    lsu_cmd_valid = 0; ext_cmd_valid = 0;
    drain();

    // single lsu read
    @(posedge clk); #1;
    issue(0, 16'h0010);
    @(negedge clk);
    chk("single_lsu_rsp_valid", lsu_rsp_valid, 1);
    chk("single_ext_rsp_valid", ext_rsp_valid, 0);
    chk("single_lsu_rdata", lsu_rsp_rdata, 32'hDEADBEEF);
    drain();

    // FIFO full, pop in the same cycle does not reopen cmd_ready
    @(posedge clk); #1;
    auto_rsp = 0; dtcm_rsp_valid = 0;
    issue(0, 16'h0020);
    issue(0, 16'h0024);
    lsu_cmd_valid = 1; lsu_cmd_addr = 16'h0028;
    exp_cmd.push_back(16'h0028);
    exp_rsp.push_back({1'b0, mem_data(16'h0028)});
    @(negedge clk);
    chk("full_cmd_ready", lsu_cmd_ready, 0);
    chk("full_dtcm_cmd_valid", dtcm_cmd_valid, 0);
    @(posedge clk); #1;
    dtcm_rsp_valid = 1; dtcm_rsp_rdata = mem_q[0];
    @(negedge clk);
    chk("full_pop_cmd_ready", lsu_cmd_ready, 0);
    chk("full_pop_rsp_valid", lsu_rsp_valid, 1);
    @(posedge clk); #1;
    dtcm_rsp_valid = 0;
    @(negedge clk);
    chk("after_pop_cmd_ready", lsu_cmd_ready, 1);
    @(posedge clk); #1;
    lsu_cmd_valid = 0; auto_rsp = 1;
    drain();

    // stalled ext command keeps the grant while lsu arrives
    @(posedge clk); #1;
    dtcm_cmd_ready = 0;
    ext_cmd_valid = 1; ext_cmd_read = 1; ext_cmd_addr = 16'h0300;
    exp_cmd.push_back(16'h0300); exp_rsp.push_back({1'b1, mem_data(16'h0300)});
    @(negedge clk);
    chk("stall_addr0", {16'h0, dtcm_cmd_addr}, 32'h0300);
    chk("stall_ext_ready0", ext_cmd_ready, 0);
    @(posedge clk); #1;
    lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 16'h0030;
    exp_cmd.push_back(16'h0030); exp_rsp.push_back({1'b0, mem_data(16'h0030)});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_addr", {16'h0, dtcm_cmd_addr}, 32'h0300);
      chk("stall_lsu_ready", lsu_cmd_ready, 0);
      @(posedge clk); #1;
    end
    dtcm_cmd_ready = 1;
    @(negedge clk);
    chk("stall_release_ext", ext_cmd_ready, 1);
    chk("stall_release_lsu", lsu_cmd_ready, 0);
    @(posedge clk); #1;
    ext_cmd_valid = 0;
    @(negedge clk);
    chk("after_stall_lsu", lsu_cmd_ready, 1);
    @(posedge clk); #1;
    lsu_cmd_valid = 0;
    drain();

    // response with nothing outstanding
    @(posedge clk); #1;
    auto_rsp = 0;
    dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h12345678;
    @(negedge clk);
    chk("spur_rsp_ready", dtcm_rsp_ready, 1);
    chk("spur_lsu_valid", lsu_rsp_valid, 0);
    chk("spur_ext_valid", ext_rsp_valid, 0);
    chk("spur_err_before", arb_err, 0);
    @(posedge clk); #1;
    dtcm_rsp_valid = 0;
    @(negedge clk);
    chk("spur_err_set", arb_err, 1);
    repeat (3) @(negedge clk);
    chk("spur_err_held", arb_err, 1);

    // reset with two outstanding commands
    @(posedge clk); #1;
    issue(0, 16'h0040);
    issue(1, 16'h0340);
    lsu_cmd_valid = 1; ext_cmd_valid = 1; dtcm_rsp_valid = 1; dtcm_rsp_rdata = 0;
    exp_rsp.delete(); exp_cmd.delete();
    rst = 1;
    #1;
    chk("mid_rst_lsu_cmd_ready", lsu_cmd_ready, 0);
    chk("mid_rst_ext_cmd_ready", ext_cmd_ready, 0);
    chk("mid_rst_dtcm_cmd_valid", dtcm_cmd_valid, 0);
    chk("mid_rst_lsu_rsp_valid", lsu_rsp_valid, 0);
    chk("mid_rst_ext_rsp_valid", ext_rsp_valid, 0);
    chk("mid_rst_arb_err", arb_err, 0);
    @(posedge clk); #1;
    lsu_cmd_valid = 0; ext_cmd_valid = 0; dtcm_rsp_valid = 0;
    @(posedge clk); #1;
    rst = 0; auto_rsp = 1;
    issue(0, 16'h0010);
    @(negedge clk);
    chk("post_rst_lsu_rsp_valid", lsu_rsp_valid, 1);
    chk("post_rst_ext_rsp_valid", ext_rsp_valid, 0);
    chk("post_rst_rdata", lsu_rsp_rdata, 32'hDEADBEEF);
    drain();
    chk("post_rst_arb_err", arb_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dtcm_arb.md
DTCM_ARB -- requirements
Module: dtcm_arb

Interface
REQ-001 SHALL have parameter DTCM_ADDR_WIDTH, default 16, DTCM byte-address width.
REQ-002 SHALL have parameter XLEN, default 32, data width; mask width XLEN/8.
REQ-003 SHALL have parameter OUTS_DEPTH, default 2, maximum outstanding commands (power of 2, >=1).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports lsu_cmd_valid in 1, lsu_cmd_ready out 1, lsu_cmd_read in 1, lsu_cmd_addr in DTCM_ADDR_WIDTH, lsu_cmd_wdata in XLEN, lsu_cmd_wmask in XLEN/8 -- requester 0 (LSU) command.
REQ-007 SHALL have ports lsu_rsp_valid out 1, lsu_rsp_ready in 1, lsu_rsp_rdata out XLEN -- requester 0 response.
REQ-008 SHALL have ports ext_cmd_* and ext_rsp_*, identical in width and meaning to REQ-006/007 -- requester 1 (external/debug) port.
REQ-009 SHALL have ports dtcm_cmd_valid out 1, dtcm_cmd_ready in 1, dtcm_cmd_read out 1, dtcm_cmd_addr out DTCM_ADDR_WIDTH, dtcm_cmd_wdata out XLEN, dtcm_cmd_wmask out XLEN/8 -- shared DTCM command.
REQ-010 SHALL have ports dtcm_rsp_valid in 1, dtcm_rsp_ready out 1, dtcm_rsp_rdata in XLEN -- shared DTCM response.
REQ-011 SHALL have port arb_err  out  1  sticky flag: unexpected DTCM response.

Function
REQ-012 SHALL grant at most one requester per cycle, combinationally from current cmd_valid inputs, arbitration state and FIFO state.
REQ-013 SHALL drive dtcm_cmd_valid = granted cmd_valid AND NOT fifo_full; dtcm_cmd_read/addr/wdata/wmask SHALL mux from the granted requester.
REQ-014 SHALL drive granted <req>_cmd_ready = dtcm_cmd_ready AND NOT fifo_full; non-granted cmd_ready SHALL be 0.
REQ-015 SHALL push the granted source ID (0=lsu, 1=ext) into an OUTS_DEPTH-entry ID FIFO on each DTCM command handshake.
REQ-016 SHALL route dtcm_rsp_valid to the requester at FIFO head only; the other rsp_valid SHALL be 0; dtcm_rsp_rdata SHALL go to both rsp_rdata outputs unregistered.
REQ-017 SHALL drive dtcm_rsp_ready = head requester's rsp_ready while FIFO non-empty; pop on DTCM response handshake.
REQ-018 SHALL, when full, hold all cmd_ready 0 even if a pop occurs that cycle (no push-through-when-full).
REQ-019 SHALL, when empty, accept a push; a response in the same cycle is handled per REQ-020, never bypassing the FIFO.
REQ-020 SHALL, on dtcm_rsp_valid with FIFO empty, drive dtcm_rsp_ready=1, drop the beat, and set arb_err=1 next edge.
REQ-021 SHALL keep FIFO pointers modulo OUTS_DEPTH with an extra wrap bit to separate full from empty.
REQ-022 SHALL add zero cycles of command or response latency (pure routing plus FIFO bookkeeping).
REQ-023 SHALL hold a granted command's mux selection stable while valid and not ready (no re-arbitration mid-stall): a 1-bit lock register set on stall, cleared on handshake.

Reset
REQ-024 SHALL, when rst is high, empty the FIFO, clear the lock, set the RR pointer to favour lsu, and clear arb_err.
REQ-025 SHALL force every cmd_ready, rsp_valid and dtcm_cmd_valid output to 0 while rst is high; reset mid-transaction discards outstanding IDs.

Configuration
REQ-026 SHALL, with DTCM_ARB_RR_EN defined, use round-robin: after each handshake, priority goes to the other requester.
REQ-027 SHALL, without DTCM_ARB_RR_EN, use fixed priority, lsu over ext; the RR pointer register is absent.

Verification
REQ-028 lsu read 0x0010 alone, dtcm_cmd_ready=1, rsp next cycle 0xDEADBEEF -> lsu_rsp_valid=1, lsu_rsp_rdata=0xDEADBEEF, ext_rsp_valid=0.
REQ-029 both valid every cycle, dtcm ready=1, rsp 1 cycle later -> RR_EN: grants lsu,ext,lsu,ext; without RR_EN: lsu only, ext_cmd_ready=0.
REQ-030 OUTS_DEPTH=2, two accepted cmds, no rsp -> third cmd sees cmd_ready=0; one rsp pop same cycle -> still 0; next cycle -> 1.
REQ-031 ext cmd stalled (dtcm_cmd_ready=0, 3 cycles) while lsu raises valid -> addr/grant remain ext until handshake.
REQ-032 dtcm_rsp_valid with FIFO empty -> dtcm_rsp_ready=1, no rsp_valid out, arb_err=1 next cycle and held until rst.
REQ-033 rst asserted with 2 outstanding -> all valid/ready outputs 0 immediately; after release a new lsu read routes correctly, arb_err=0.
